// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage sequencing states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem.sv
// Byte-addressed data memory: one combinational little-endian 8-byte read
// port and one synchronous 8-byte write port. Contents are never cleared.
module dmem #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[wr_addr + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      rd_data[8*i +: 8] = mem[rd_addr + AW'(i)];
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: address selection, bounds check, data memory access,
// status computation and a RUN/HALTED sequencer with one-cycle result latency.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        imem_error,
  input  logic        instr_valid,
  output logic        out_valid,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat,
  output logic [31:0] instr_count
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  mem_state_e  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] valm_q, valm_d;
  logic        dmem_error_q, dmem_error_d;
  stat_e       stat_q, stat_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic          is_read, is_write, addr_fault, accept, wr_en;
  logic [63:0]   addr, wr_data, rd_data;
  logic [AW-1:0] mem_addr;
  stat_e         stat_nxt;

  // Decode: popq/ret read through valA, everything else addresses with valE.
  always_comb begin
    is_read    = (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    is_write   = (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    addr       = ((icode == I_POPQ) || (icode == I_RET)) ? valA : valE;
    wr_data    = (icode == I_CALL) ? valP : valA;
    addr_fault = (is_read || is_write) && (addr > MAX_ADDR);
    mem_addr   = addr_fault ? '0 : addr[AW-1:0];

    if (addr_fault || imem_error)  stat_nxt = STAT_ADR;
    else if (!instr_valid)         stat_nxt = STAT_INS;
    else if (icode == I_HALT)      stat_nxt = STAT_HLT;
    else                           stat_nxt = STAT_AOK;

    accept = (state_q == ST_RUN) && in_valid;
    wr_en  = accept && !reset && is_write && (stat_nxt == STAT_AOK);
  end

  dmem #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_dmem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(mem_addr),
    .wr_data(wr_data),
    .rd_addr(mem_addr),
    .rd_data(rd_data)
  );

  // Results hold their last values whenever nothing is accepted.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = 1'b0;
    valm_d        = valm_q;
    dmem_error_d  = dmem_error_q;
    stat_d        = stat_q;
    instr_count_d = instr_count_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      valm_d       = (is_read && !addr_fault) ? rd_data : 64'd0;
      dmem_error_d = addr_fault;
      stat_d       = stat_nxt;
      if (stat_nxt == STAT_AOK) instr_count_d = instr_count_q + 32'd1;
      else                      state_d       = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      out_valid_q   <= 1'b0;
      valm_q        <= '0;
      dmem_error_q  <= 1'b0;
      stat_q        <= STAT_AOK;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      valm_q        <= valm_d;
      dmem_error_q  <= dmem_error_d;
      stat_q        <= stat_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign valM        = valm_q;
  assign dmem_error  = dmem_error_q;
  assign stat        = stat_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [63:0] valE = '0, valA = '0, valP = '0;
  logic        imem_error = 1'b0;
  logic        instr_valid = 1'b1;
  logic        out_valid;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP), .imem_error(imem_error),
    .instr_valid(instr_valid), .out_valid(out_valid), .valM(valM),
    .dmem_error(dmem_error), .stat(stat), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Drive one instruction at the falling edge, sample 1 time unit after the rising edge.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    @(negedge clk);
    in_valid = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; imem_error = 1'b0; instr_valid = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (valM !== 64'd0) begin failures++; $display("[TB] FAIL rst_valM: got %h want 0", valM); end
    checks++; if (dmem_error !== 1'b0) begin failures++; $display("[TB] FAIL rst_dmem_error: got %0b want 0", dmem_error); end
    checks++; if (stat !== 3'd1) begin failures++; $display("[TB] FAIL rst_stat: got %0d want 1", stat); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d want 0", instr_count); end
  endtask

  task automatic test_store_load();
    issue(4'h4, 64'h18, 64'h0, 64'h0);
    issue(4'h4, 64'h10, 64'h1122334455667788, 64'h0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL st_out_valid: got %0b want 1", out_valid); end
    checks++; if (stat !== 3'd1 || dmem_error !== 1'b0) begin failures++; $display("[TB] FAIL st_stat: got %0d/%0b want 1/0", stat, dmem_error); end
    checks++; if (valM !== 64'd0) begin failures++; $display("[TB] FAIL st_valM: got %h want 0", valM); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("[TB] FAIL st_count: got %0d want 2", instr_count); end
    issue(4'h5, 64'h10, 64'h0, 64'h0);
    checks++; if (valM !== 64'h1122334455667788 || stat !== 3'd1) begin failures++; $display("[TB] FAIL ld_aligned: got %h/%0d want 1122334455667788/1", valM, stat); end
    issue(4'h5, 64'h13, 64'h0, 64'h0);
    checks++; if (valM !== 64'h0000001122334455) begin failures++; $display("[TB] FAIL ld_unaligned: got %h want 0000001122334455", valM); end
    idle();
    checks++; if (out_valid !== 1'b0 || valM !== 64'h0000001122334455) begin failures++; $display("[TB] FAIL idle_hold: got %0b/%h want 0/0000001122334455", out_valid, valM); end
    checks++; if (instr_count !== 32'd4) begin failures++; $display("[TB] FAIL ld_count: got %0d want 4", instr_count); end
  endtask

  task automatic test_call_ret();
    issue(4'h8, 64'h1F8, 64'h0, 64'h40);
    issue(4'h9, 64'h208, 64'h1F8, 64'h0);
    checks++; if (valM !== 64'h40 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ret_valM: got %h/%0b want 40/1", valM, out_valid); end
    checks++; if (instr_count !== 32'd6) begin failures++; $display("[TB] FAIL ret_count: got %0d want 6", instr_count); end
  endtask

  task automatic test_back_to_back();
    issue(4'hA, 64'h14, 64'hAABBCCDDEEFF0011, 64'h0);
    issue(4'h5, 64'h10, 64'h0, 64'h0);
    checks++; if (valM !== 64'hEEFF001155667788) begin failures++; $display("[TB] FAIL overlap_rd: got %h want eeff001155667788", valM); end
    issue(4'hB, 64'h0, 64'h18, 64'h0);
    checks++; if (valM !== 64'h00000000AABBCCDD) begin failures++; $display("[TB] FAIL pop_rd: got %h want 00000000aabbccdd", valM); end
    checks++; if (instr_count !== 32'd9) begin failures++; $display("[TB] FAIL b2b_count: got %0d want 9", instr_count); end
  endtask

  task automatic test_adr();
    issue(4'h4, 64'd1016, 64'h0123456789ABCDEF, 64'h0);
    issue(4'h5, 64'd1016, 64'h0, 64'h0);
    checks++; if (valM !== 64'h0123456789ABCDEF || dmem_error !== 1'b0) begin failures++; $display("[TB] FAIL top_edge: got %h/%0b want 0123456789abcdef/0", valM, dmem_error); end
    issue(4'hA, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFDEADBEEF, 64'h0);
    checks++; if (dmem_error !== 1'b1 || stat !== 3'd3 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL big_addr: got %0b/%0d/%0b want 1/3/1", dmem_error, stat, out_valid); end
    checks++; if (instr_count !== 32'd11) begin failures++; $display("[TB] FAIL adr_count: got %0d want 11", instr_count); end
    issue(4'h5, 64'h10, 64'h0, 64'h0);
    checks++; if (out_valid !== 1'b0 || stat !== 3'd3 || dmem_error !== 1'b1) begin failures++; $display("[TB] FAIL halted_ignore: got %0b/%0d/%0b want 0/3/1", out_valid, stat, dmem_error); end
    do_reset();
    issue(4'h5, 64'd1016, 64'h0, 64'h0);
    checks++; if (valM !== 64'h0123456789ABCDEF) begin failures++; $display("[TB] FAIL adr_no_write: got %h want 0123456789abcdef", valM); end
    issue(4'h5, 64'd1017, 64'h0, 64'h0);
    checks++; if (dmem_error !== 1'b1 || stat !== 3'd3) begin failures++; $display("[TB] FAIL edge_plus1: got %0b/%0d want 1/3", dmem_error, stat); end
    issue(4'h1, 64'h0, 64'h0, 64'h0);
    checks++; if (out_valid !== 1'b0 || instr_count !== 32'd1) begin failures++; $display("[TB] FAIL adr_halted: got %0b/%0d want 0/1", out_valid, instr_count); end
    do_reset();
  endtask

  task automatic test_halt();
    issue(4'h0, 64'h0, 64'h0, 64'h0);
    checks++; if (stat !== 3'd2 || out_valid !== 1'b1 || dmem_error !== 1'b0) begin failures++; $display("[TB] FAIL halt_stat: got %0d/%0b/%0b want 2/1/0", stat, out_valid, dmem_error); end
    issue(4'h4, 64'h10, 64'hDEADBEEFDEADBEEF, 64'h0);
    checks++; if (out_valid !== 1'b0 || instr_count !== 32'd0) begin failures++; $display("[TB] FAIL halt_ignore: got %0b/%0d want 0/0", out_valid, instr_count); end
    do_reset();
    issue(4'h5, 64'h10, 64'h0, 64'h0);
    checks++; if (valM !== 64'hEEFF001155667788) begin failures++; $display("[TB] FAIL halt_mem: got %h want eeff001155667788", valM); end
  endtask

  task automatic test_reset_collision();
    issue(4'h4, 64'h20, 64'h5555AAAA5555AAAA, 64'h0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; icode = 4'hA; valE = 64'h20; valA = 64'h0F0F0F0F0F0F0F0F;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || instr_count !== 32'd0) begin failures++; $display("[TB] FAIL coll_out: got %0b/%0d want 0/0", out_valid, instr_count); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    issue(4'h5, 64'h20, 64'h0, 64'h0);
    checks++; if (valM !== 64'h5555AAAA5555AAAA || out_valid !== 1'b1 || stat !== 3'd1) begin failures++; $display("[TB] FAIL coll_mem: got %h/%0b/%0d want 5555aaaa5555aaaa/1/1", valM, out_valid, stat); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("[TB] FAIL coll_count: got %0d want 1", instr_count); end
  endtask

  task automatic test_wrap_ins();
    @(negedge clk);
    force dut.instr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.instr_count_q;
    issue(4'h1, 64'h0, 64'h0, 64'h0);
    checks++; if (instr_count !== 32'd0 || stat !== 3'd1 || valM !== 64'd0) begin failures++; $display("[TB] FAIL wrap: got %h/%0d/%h want 0/1/0", instr_count, stat, valM); end
    instr_valid = 1'b0;
    issue(4'h1, 64'h0, 64'h0, 64'h0);
    checks++; if (stat !== 3'd4 || instr_count !== 32'd0) begin failures++; $display("[TB] FAIL ins_stat: got %0d/%0d want 4/0", stat, instr_count); end
    instr_valid = 1'b1;
    issue(4'h1, 64'h0, 64'h0, 64'h0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ins_halted: got %0b want 0", out_valid); end
    do_reset();
    imem_error = 1'b1;
    issue(4'h1, 64'h0, 64'h0, 64'h0);
    checks++; if (stat !== 3'd3 || dmem_error !== 1'b0) begin failures++; $display("[TB] FAIL imem_adr: got %0d/%0b want 3/0", stat, dmem_error); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_call_ret();
    test_back_to_back();
    test_adr();
    test_halt();
    test_reset_collision();
    test_wrap_ins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
